// File: rtl/axi_master_port.sv
// axi_master_port: AXI4 initiator bridging a one-request-at-a-time command
// interface onto AXI4. Writes are single-beat; reads are INCR bursts of
// 1..16 beats streamed back to the requester.
//
// Ports:
//   ACLK, ARESETn        clock, asynchronous active-low reset
//   req_*                command channel (valid/ready, write, addr, len, size, wdata, wstrb)
//   rd_valid/rd_ready    read beat stream (rd_data, rd_last)
//   done/err             one-cycle completion pulse with error flag
//   AW/W/B/AR/R          AXI4 master channels
module axi_master_port #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MASTER_ID = 0
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [3:0]          req_len,
  input  logic [2:0]          req_size,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                done,
  output logic                err,
  output logic [ID_W-1:0]     AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [7:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [ID_W-1:0]     BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ID_W-1:0]     ARID,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [7:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [ID_W-1:0]     RID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ID_W-1:0] MY_ID = ID_W'(MASTER_ID);

  typedef enum logic [2:0] {S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          len_q;
  logic [2:0]          size_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                aw_done, aw_done_d;
  logic                w_done, w_done_d;
  logic [4:0]          beat_cnt, beat_cnt_d;
  logic                err_acc, err_acc_d;
  logic                done_d, err_d;
  logic                accept, last_beat, beat_err;

  assign accept    = req_valid & req_ready;
  assign req_ready = (state == S_IDLE);

  // Write address and data are tracked separately; each VALID falls as soon
  // as its own handshake has been recorded.
  assign AWVALID = (state == S_WADDR) & ~aw_done;
  assign WVALID  = (state == S_WADDR) & ~w_done;
  assign BREADY  = (state == S_WRESP);
  assign ARVALID = (state == S_RADDR);
  assign RREADY  = (state == S_RDATA) & rd_ready;

  assign AWID    = MY_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = '0;
  assign AWSIZE  = size_q;
  assign AWBURST = 2'b01;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WLAST   = 1'b1;
  assign ARID    = MY_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = {4'b0000, len_q};
  assign ARSIZE  = size_q;
  assign ARBURST = 2'b01;

  // Burst end is decided by the local beat counter, never by RLAST, so a
  // misbehaving slave cannot truncate the stream seen by the requester.
  assign last_beat = (beat_cnt == {1'b0, len_q});
  assign rd_valid  = (state == S_RDATA) & RVALID;
  assign rd_data   = RDATA;
  assign rd_last   = rd_valid & last_beat;
  assign beat_err  = (RRESP != 2'b00) | (RID != MY_ID) | (RLAST != last_beat);

  always_comb begin
    state_d    = state;
    aw_done_d  = aw_done;
    w_done_d   = w_done;
    beat_cnt_d = beat_cnt;
    err_acc_d  = err_acc;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_d    = req_write ? S_WADDR : S_RADDR;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          beat_cnt_d = '0;
          err_acc_d  = 1'b0;
        end
      end
      S_WADDR: begin
        aw_done_d = aw_done | AWREADY;
        w_done_d  = w_done | WREADY;
        if (aw_done_d && w_done_d) state_d = S_WRESP;
      end
      S_WRESP: begin
        if (BVALID) begin
          done_d  = 1'b1;
          err_d   = (BRESP != 2'b00) | (BID != MY_ID);
          state_d = S_IDLE;
        end
      end
      S_RADDR: begin
        if (ARREADY) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (RVALID && RREADY) begin
          beat_cnt_d = beat_cnt + 5'd1;
          err_acc_d  = err_acc | beat_err;
          if (last_beat) begin
            done_d  = 1'b1;
            err_d   = err_acc | beat_err;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      beat_cnt <= '0;
      err_acc  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      aw_done  <= aw_done_d;
      w_done   <= w_done_d;
      beat_cnt <= beat_cnt_d;
      err_acc  <= err_acc_d;
      done     <= done_d;
      err      <= err_d;
      if (accept) begin
        addr_q  <= req_addr;
        len_q   <= req_len;
        size_q  <= req_size;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
    end
  end

endmodule

// File: tb/tb_axi_master_port.sv
// Scoreboard bench for axi_master_port: directed commands push expected AXI
// payloads, read beats and completions into queues; a monitor pops and
// compares them whenever the DUT presents the matching event.
module tb_axi_master_port;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic [2:0]  req_size = 3'd2;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rd_valid, rd_ready = 1'b1, rd_last, done, err;
  logic [31:0] rd_data;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  axi_master_port #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .MASTER_ID(0)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial forever #5 ACLK = ~ACLK;

  int cyc = 0;
  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected or not seen (cycle %0d)", name, cyc);
  endtask

  typedef struct {logic e; int lat;} done_t;
  typedef struct {logic [31:0] d; logic l;} rbeat_t;

  logic [31:0] exp_aw[$];
  logic [36:0] exp_w[$];
  logic [39:0] exp_ar[$];
  rbeat_t      exp_rd[$];
  done_t       exp_done[$];

  // Slave behaviour knobs
  int         cfg_aw_dly = 0, cfg_w_dly = 0;
  logic [1:0] cfg_bresp = 2'b00;
  logic [3:0] cfg_bid = 4'd0, cfg_rid = 4'd0;
  int         cfg_rresp_beat = -1;
  logic [1:0] cfg_rresp_val = 2'b00;
  int         cfg_rlast_at = -1;

  // AXI slave model: decides its outputs on the falling edge; handshakes
  // found there take effect at the following rising edge.
  initial begin
    logic hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_got, w_got, r_active;
    int aw_cnt, w_cnt, r_wait, r_beat, r_len, lastpos;
    logic [31:0] r_addr, ar_addr_s;
    logic [7:0] ar_len_s;
    {hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_got, w_got, r_active} = '0;
    aw_cnt = 0; w_cnt = 0; r_wait = 0; r_beat = 0; r_len = 0;
    r_addr = '0; ar_addr_s = '0; ar_len_s = '0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; BID = 0; ARREADY = 0;
    RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RID = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        {hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_got, w_got, r_active} = '0;
        aw_cnt = 0; w_cnt = 0; r_wait = 0; r_beat = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RLAST = 0;
        continue;
      end
      if (hs_aw) aw_got = 1'b1;
      if (hs_w)  w_got = 1'b1;
      if (hs_b) begin
        aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0;
      end
      if (hs_ar) begin
        r_active = 1'b1; r_wait = 1; r_beat = 0;
        r_len = int'(ar_len_s); r_addr = ar_addr_s;
      end
      if (hs_r) begin
        r_beat++;
        if (r_beat > r_len) r_active = 1'b0;
      end
      AWREADY = 1'b0;
      if (AWVALID && !aw_got) begin
        AWREADY = (aw_cnt >= cfg_aw_dly);
        aw_cnt++;
      end
      WREADY = 1'b0;
      if (WVALID && !w_got) begin
        WREADY = (w_cnt >= cfg_w_dly);
        w_cnt++;
      end
      BVALID = aw_got && w_got;
      BRESP = cfg_bresp;
      BID = cfg_bid;
      ARREADY = 1'b1;
      RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
      if (r_active) begin
        if (r_wait > 0) r_wait--;
        else begin
          lastpos = (cfg_rlast_at >= 0) ? cfg_rlast_at : r_len;
          RVALID = 1'b1;
          RDATA = r_addr + 32'(r_beat);
          RRESP = (r_beat == cfg_rresp_beat) ? cfg_rresp_val : 2'b00;
          RLAST = (r_beat == lastpos);
          RID = cfg_rid;
        end
      end
      hs_aw = AWVALID && AWREADY;
      hs_w  = WVALID && WREADY;
      hs_b  = BVALID && BREADY;
      hs_ar = ARVALID && ARREADY;
      if (hs_ar) begin
        ar_addr_s = ARADDR; ar_len_s = ARLEN;
      end
      hs_r  = RVALID && RREADY;
    end
  end

  // Monitor / scoreboard
  int beats = 0;
  initial begin
    int acc_cyc;
    logic aw_seen, w_seen, prev_aw, prev_w, prev_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0] p_wstrb;
    logic [7:0] p_arlen;
    logic [31:0] ea;
    logic [36:0] ew;
    logic [39:0] ear;
    rbeat_t rb;
    done_t dd;
    acc_cyc = 0;
    {aw_seen, w_seen, prev_aw, prev_w, prev_ar} = '0;
    p_awaddr = '0; p_wdata = '0; p_araddr = '0; p_wstrb = '0; p_arlen = '0;
    forever begin
      @(negedge ACLK);
      #1;
      if (!ARESETn) begin
        {prev_aw, prev_w, prev_ar} = '0;
        continue;
      end
      if (BREADY) chk("bready_after_both", 64'({aw_seen, w_seen}), 64'(2'b11));
      if (aw_seen) chk("awvalid_dropped", 64'(AWVALID), 64'(0));
      if (w_seen)  chk("wvalid_dropped", 64'(WVALID), 64'(0));
      if (prev_aw) chk("aw_hold", 64'({AWVALID, AWADDR}), 64'({1'b1, p_awaddr}));
      if (prev_w)  chk("w_hold", 64'({WVALID, WDATA, WSTRB}), 64'({1'b1, p_wdata, p_wstrb}));
      if (prev_ar) chk("ar_hold", 64'({ARVALID, ARADDR, ARLEN}), 64'({1'b1, p_araddr, p_arlen}));
      if (!rd_ready) chk("rready_follows", 64'(RREADY), 64'(0));
      if (req_valid && req_ready) begin
        acc_cyc = cyc; aw_seen = 1'b0; w_seen = 1'b0;
      end
      if (AWVALID && AWREADY) begin
        if (exp_aw.size() == 0) note_fail("aw_unexpected");
        else begin
          ea = exp_aw.pop_front();
          chk("aw_addr", 64'(AWADDR), 64'(ea));
          chk("aw_ctl", 64'({AWLEN, AWSIZE, AWBURST, AWID}), 64'({8'd0, 3'd2, 2'b01, 4'd0}));
        end
        aw_seen = 1'b1;
      end
      if (WVALID && WREADY) begin
        if (exp_w.size() == 0) note_fail("w_unexpected");
        else begin
          ew = exp_w.pop_front();
          chk("w_payload", 64'({WDATA, WSTRB, WLAST}), 64'(ew));
        end
        w_seen = 1'b1;
      end
      if (ARVALID && ARREADY) begin
        if (exp_ar.size() == 0) note_fail("ar_unexpected");
        else begin
          ear = exp_ar.pop_front();
          chk("ar_addr_len", 64'({ARADDR, ARLEN}), 64'(ear));
          chk("ar_ctl", 64'({ARSIZE, ARBURST, ARID}), 64'({3'd2, 2'b01, 4'd0}));
        end
      end
      if (rd_valid && rd_ready) begin
        chk("rready_on", 64'(RREADY), 64'(1));
        if (exp_rd.size() == 0) note_fail("rd_unexpected");
        else begin
          rb = exp_rd.pop_front();
          chk("rd_beat", 64'({rd_data, rd_last}), 64'({rb.d, rb.l}));
        end
        beats++;
      end
      if (done) begin
        if (exp_done.size() == 0) note_fail("done_unexpected");
        else begin
          dd = exp_done.pop_front();
          chk("done_err", 64'(err), 64'(dd.e));
          if (dd.lat >= 0) chk("done_latency", 64'(cyc - acc_cyc), 64'(dd.lat));
        end
      end
      prev_aw  = AWVALID && !AWREADY; p_awaddr = AWADDR;
      prev_w   = WVALID && !WREADY;   p_wdata = WDATA; p_wstrb = WSTRB;
      prev_ar  = ARVALID && !ARREADY; p_araddr = ARADDR; p_arlen = ARLEN;
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] len,
                       input logic [31:0] d, input logic [3:0] s);
    bit ok;
    ok = 1'b0;
    @(posedge ACLK);
    #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = len;
    req_size = 3'd2; req_wdata = d; req_wstrb = s;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      #2;
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) note_fail("req_accept_timeout");
    @(posedge ACLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_done.size() != 0 && n < 300) begin
      @(posedge ACLK);
      n++;
    end
    if (exp_done.size() != 0) begin
      note_fail("done_timeout");
      exp_done.delete();
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic e, input int lat);
    exp_aw.push_back(a);
    exp_w.push_back({d, s, 1'b1});
    exp_done.push_back('{e: e, lat: lat});
    issue(1'b1, a, 4'd0, d, s);
    wait_done();
  endtask

  task automatic push_read(input logic [31:0] a, input logic [3:0] len, input logic e, input int lat);
    exp_ar.push_back({a, 4'd0, len});
    for (int i = 0; i <= int'(len); i++)
      exp_rd.push_back('{d: a + 32'(i), l: (i == int'(len))});
    exp_done.push_back('{e: e, lat: lat});
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] len, input logic e, input int lat);
    push_read(a, len, e, lat);
    issue(1'b0, a, len, '0, '0);
    wait_done();
  endtask

  initial begin
    int b0;
    ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("reset_ctrl", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY, done, err, rd_valid}), 64'(0));
    chk("reset_regs", 64'({AWADDR, WDATA}), 64'(0));
    chk("reset_strb_ar", 64'({WSTRB, ARADDR}), 64'(0));
    chk("reset_req_ready", 64'(req_ready), 64'(1));
    @(posedge ACLK);
    #2;
    ARESETn = 1'b1;

    // Basic write and read, zero-wait slave
    do_write(32'h1001_0100, 32'h0000_0001, 4'hF, 1'b0, 3);
    do_read(32'h0000_1000, 4'd3, 1'b0, 7);

    // WREADY two cycles ahead of AWREADY
    cfg_aw_dly = 2;
    do_write(32'h1001_0200, 32'hDEAD_BEEF, 4'h3, 1'b0, 5);
    cfg_aw_dly = 0;

    // Error responses, then clean requests
    cfg_bresp = 2'b10;
    do_write(32'h1001_0300, 32'h0000_0005, 4'hF, 1'b1, 3);
    cfg_bresp = 2'b00;
    cfg_rresp_beat = 1; cfg_rresp_val = 2'b11;
    do_read(32'h0000_2000, 4'd2, 1'b1, 6);
    cfg_rresp_beat = -1;
    do_write(32'h1001_0100, 32'h0000_0000, 4'hF, 1'b0, 3);
    cfg_bid = 4'd3;
    do_write(32'h1001_0104, 32'h1234_5678, 4'hC, 1'b1, 3);
    cfg_bid = 4'd0;
    cfg_rid = 4'd5;
    do_read(32'h0000_2100, 4'd0, 1'b1, 4);
    cfg_rid = 4'd0;
    cfg_rlast_at = 1;
    do_read(32'h0000_2200, 4'd3, 1'b1, 7);
    cfg_rlast_at = -1;
    do_read(32'h0000_2300, 4'd1, 1'b0, 5);

    // Requester back-pressure mid-burst
    b0 = beats;
    fork
      do_read(32'h0000_3000, 4'd7, 1'b0, -1);
      begin
        for (int i = 0; i < 100 && beats < b0 + 2; i++) @(posedge ACLK);
        #1;
        rd_ready = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        rd_ready = 1'b1;
      end
    join

    // Reset during beat 2 of an 8-beat read: no completion may follow
    b0 = beats;
    push_read(32'h0000_5000, 4'd7, 1'b0, -1);
    issue(1'b0, 32'h0000_5000, 4'd7, '0, '0);
    for (int i = 0; i < 100 && beats < b0 + 1; i++) @(posedge ACLK);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY, done, err, rd_valid}), 64'(0));
    chk("midrst_req_ready", 64'(req_ready), 64'(1));
    exp_rd.delete();
    exp_done.delete();
    @(negedge ACLK);
    @(posedge ACLK);
    #2;
    ARESETn = 1'b1;
    #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'(1));
    repeat (6) @(posedge ACLK);

    // Full 16-beat burst, then a write
    do_read(32'h0000_4000, 4'd15, 1'b0, 19);
    do_write(32'h1001_0300, 32'hCAFE_F00D, 4'h1, 1'b0, 3);

    repeat (4) @(posedge ACLK);
    chk("queues_empty", 64'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_rd.size() + exp_done.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
